// File: rtl/core_pkg.sv
// Shared core types and constants: datapath widths, pipeline stage indices
// and the RAW scoreboard entry.
package core_pkg;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  localparam int STAGE_EX  = 0;
  localparam int STAGE_MEM = 1;
  localparam int STAGE_WB  = 2;

  typedef struct packed {
    logic               vld;
    logic [RADDR_W-1:0] rd;
    logic               we;
    logic               ld;
  } sb_entry_t;

endpackage

// File: rtl/raw_fwd_select.sv
// Per-source RAW resolver: finds the youngest in-flight writer of src and
// either forwards its stage result or reports a not-yet-ready hazard.
module raw_fwd_select
  import core_pkg::*;
#(
  parameter int XLEN       = core_pkg::XLEN,
  parameter int DEPTH      = STAGE_WB + 1,
  parameter int ALU_READY  = STAGE_EX,
  parameter int LOAD_READY = STAGE_MEM
) (
  input  logic [core_pkg::RADDR_W-1:0] src,
  input  logic                         used,
  input  sb_entry_t [DEPTH-1:0]        sb,
  input  logic [DEPTH*XLEN-1:0]        stage_data,
  output logic                         hazard,
  output logic                         fwd_en,
  output logic [XLEN-1:0]              fwd_data
);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    hazard   = 1'b0;
    fwd_en   = 1'b0;
    fwd_data = '0;
    // Oldest to youngest: the last match written is the youngest producer.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (used && (src != '0) && sb[i].vld && sb[i].we && (sb[i].rd == src)) begin
        if (i >= (sb[i].ld ? LOAD_READY : ALU_READY)) begin
          hazard   = 1'b0;
          fwd_en   = 1'b1;
          fwd_data = stage_data[i*XLEN +: XLEN];
        end else begin
          hazard   = 1'b1;
          fwd_en   = 1'b0;
          fwd_data = '0;
        end
      end
    end
  end

endmodule

// File: rtl/raw_hazard_unit.sv
// RAW hazard tracker and forwarding unit: shift-register scoreboard behind
// decode, per-source forwarding and load-use stall. Optional RAW_HAZ_PERF_EN
// adds saturating stall / forward event counters.
module raw_hazard_unit
  import core_pkg::*;
#(
  parameter int XLEN       = core_pkg::XLEN,
  parameter int RADDR_W    = core_pkg::RADDR_W,
  parameter int DEPTH      = STAGE_WB + 1,
  parameter int ALU_READY  = STAGE_EX,
  parameter int LOAD_READY = STAGE_MEM
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    id_valid,
  input  logic [RADDR_W-1:0]      id_rs1,
  input  logic [RADDR_W-1:0]      id_rs2,
  input  logic                    id_rs1_used,
  input  logic                    id_rs2_used,
  input  logic [RADDR_W-1:0]      id_rd,
  input  logic                    id_rd_we,
  input  logic                    id_is_load,
  input  logic [DEPTH*XLEN-1:0]   stage_data,
  output logic                    stall,
  output logic                    fwd1_en,
  output logic [XLEN-1:0]         fwd1_data,
  output logic                    fwd2_en,
  output logic [XLEN-1:0]         fwd2_data
`ifdef RAW_HAZ_PERF_EN
  ,
  output logic [31:0]             perf_stall_cnt,
  output logic [31:0]             perf_fwd_cnt
`endif
);

  if (LOAD_READY >= DEPTH || ALU_READY > LOAD_READY || ALU_READY < 0) begin : g_bad_ready
    $error("raw_hazard_unit: need 0 <= ALU_READY <= LOAD_READY < DEPTH");
  end
  if (RADDR_W != core_pkg::RADDR_W) begin : g_bad_raddr
    $error("raw_hazard_unit: RADDR_W must match core_pkg::RADDR_W");
  end

  sb_entry_t [DEPTH-1:0] sb_q;
  logic                  haz1;
  logic                  haz2;

  // NOTE: the scoreboard is cleared by reset even though it is storage:
  // a stale vld bit would otherwise raise phantom stalls after reset.
  // NOTE: sequential state uses non-blocking assignments so the shift reads
  // every entry's pre-edge value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_q <= '0;
    end else if (flush) begin
      sb_q <= '0;
    end else begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        sb_q[i] <= sb_q[i-1];
      end
      sb_q[0] <= '{vld: id_valid & ~stall, rd: id_rd, we: id_rd_we, ld: id_is_load};
    end
  end

  raw_fwd_select #(
    .XLEN(XLEN), .DEPTH(DEPTH), .ALU_READY(ALU_READY), .LOAD_READY(LOAD_READY)
  ) u_sel_rs1 (
    .src(id_rs1), .used(id_rs1_used), .sb(sb_q), .stage_data(stage_data),
    .hazard(haz1), .fwd_en(fwd1_en), .fwd_data(fwd1_data)
  );

  raw_fwd_select #(
    .XLEN(XLEN), .DEPTH(DEPTH), .ALU_READY(ALU_READY), .LOAD_READY(LOAD_READY)
  ) u_sel_rs2 (
    .src(id_rs2), .used(id_rs2_used), .sb(sb_q), .stage_data(stage_data),
    .hazard(haz2), .fwd_en(fwd2_en), .fwd_data(fwd2_data)
  );

  assign stall = id_valid & (haz1 | haz2);

`ifdef RAW_HAZ_PERF_EN
  logic [32:0] fwd_sum;

  always_comb begin
    fwd_sum = {1'b0, perf_fwd_cnt} + 33'(fwd1_en) + 33'(fwd2_en);
  end

  // Counters ignore flush: they measure the pipeline, not the instruction stream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else begin
      if (stall && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (id_valid && !stall) begin
        perf_fwd_cnt <= fwd_sum[32] ? '1 : fwd_sum[31:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_raw_hazard_unit.sv
// Self-checking bench for raw_hazard_unit: directed pipeline scenarios with
// literal expectations, then randomized traffic against an in-flight list model.
module tb_raw_hazard_unit;

  localparam int XLEN       = 32;
  localparam int RADDR_W    = 5;
  localparam int DEPTH      = 3;
  localparam int ALU_READY  = 0;
  localparam int LOAD_READY = 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  flush = 1'b0;
  logic                  id_valid = 1'b0;
  logic [RADDR_W-1:0]    id_rs1 = '0;
  logic [RADDR_W-1:0]    id_rs2 = '0;
  logic                  id_rs1_used = 1'b0;
  logic                  id_rs2_used = 1'b0;
  logic [RADDR_W-1:0]    id_rd = '0;
  logic                  id_rd_we = 1'b0;
  logic                  id_is_load = 1'b0;
  logic [DEPTH*XLEN-1:0] stage_data = '0;
  logic                  stall;
  logic                  fwd1_en;
  logic [XLEN-1:0]       fwd1_data;
  logic                  fwd2_en;
  logic [XLEN-1:0]       fwd2_data;
`ifdef RAW_HAZ_PERF_EN
  logic [31:0]           perf_stall_cnt;
  logic [31:0]           perf_fwd_cnt;
`endif

  always #5 clk = ~clk;

  raw_hazard_unit #(
    .XLEN(XLEN), .RADDR_W(RADDR_W), .DEPTH(DEPTH),
    .ALU_READY(ALU_READY), .LOAD_READY(LOAD_READY)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_is_load(id_is_load), .stage_data(stage_data),
    .stall(stall), .fwd1_en(fwd1_en), .fwd1_data(fwd1_data),
    .fwd2_en(fwd2_en), .fwd2_data(fwd2_data)
`ifdef RAW_HAZ_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: list of instructions that left decode and write a register, each
  // tagged with how many cycles it has been in flight (age == stage index).
  typedef struct {
    logic [RADDR_W-1:0] rd;
    logic               ld;
    int                 age;
  } prod_t;

  prod_t           inflight[$];
  logic            m_stall, m_h1, m_h2, m_en1, m_en2;
  logic [XLEN-1:0] m_d1, m_d2;
  longint          m_pstall = 0;
  longint          m_pfwd   = 0;

  task automatic model_src(input logic [RADDR_W-1:0] src, input logic used,
                           output logic haz, output logic en, output logic [XLEN-1:0] data);
    int best;
    int need;
    best = -1;
    haz  = 1'b0;
    en   = 1'b0;
    data = '0;
    if (used && src != '0) begin
      foreach (inflight[k]) begin
        if (inflight[k].rd == src && (best < 0 || inflight[k].age < inflight[best].age)) best = k;
      end
    end
    if (best >= 0) begin
      need = inflight[best].ld ? LOAD_READY : ALU_READY;
      if (inflight[best].age >= need) begin
        en   = 1'b1;
        data = stage_data[inflight[best].age*XLEN +: XLEN];
      end else begin
        haz = 1'b1;
      end
    end
  endtask

  task automatic model_eval();
    model_src(id_rs1, id_rs1_used, m_h1, m_en1, m_d1);
    model_src(id_rs2, id_rs2_used, m_h2, m_en2, m_d2);
    m_stall = id_valid & (m_h1 | m_h2);
  endtask

  task automatic model_advance();
    model_eval();
    if (!rst) begin
      inflight.delete();
      m_pstall = 0;
      m_pfwd   = 0;
    end else begin
      if (m_stall) m_pstall = (m_pstall < 64'hFFFF_FFFF) ? m_pstall + 1 : m_pstall;
      if (id_valid && !m_stall) begin
        m_pfwd = m_pfwd + int'(m_en1) + int'(m_en2);
        if (m_pfwd > 64'hFFFF_FFFF) m_pfwd = 64'hFFFF_FFFF;
      end
      if (flush) begin
        inflight.delete();
      end else begin
        for (int k = inflight.size() - 1; k >= 0; k--) begin
          inflight[k].age++;
          if (inflight[k].age >= DEPTH) inflight.delete(k);
        end
        if (id_valid && !m_stall && id_rd_we) inflight.push_back('{rd: id_rd, ld: id_is_load, age: 0});
      end
    end
  endtask

  // The single compare point: every output against the model.
  task automatic compare();
    model_eval();
    check("stall", 32'(stall), 32'(m_stall));
    check("fwd1_en", 32'(fwd1_en), 32'(m_en1));
    check("fwd2_en", 32'(fwd2_en), 32'(m_en2));
    if (!m_h1) check("fwd1_data", fwd1_data, m_d1);
    if (!m_h2) check("fwd2_data", fwd2_data, m_d2);
`ifdef RAW_HAZ_PERF_EN
    check("perf_stall_cnt", perf_stall_cnt, 32'(m_pstall));
    check("perf_fwd_cnt", perf_fwd_cnt, 32'(m_pfwd));
`endif
  endtask

  task automatic set_id(input logic v, input logic [RADDR_W-1:0] rs1, input logic u1,
                        input logic [RADDR_W-1:0] rs2, input logic u2,
                        input logic [RADDR_W-1:0] rd, input logic we, input logic ld);
    id_valid = v;  id_rs1 = rs1;  id_rs1_used = u1;  id_rs2 = rs2;  id_rs2_used = u2;
    id_rd = rd;    id_rd_we = we; id_is_load = ld;
  endtask

  task automatic rand_stage();
    for (int i = 0; i < DEPTH; i++) stage_data[i*XLEN +: XLEN] = $urandom;
  endtask

  task automatic set_stage(input logic [XLEN-1:0] w0, input logic [XLEN-1:0] w1, input logic [XLEN-1:0] w2);
    stage_data = {w2, w1, w0};
  endtask

  task automatic settle();
    #1;
    compare();
  endtask

  task automatic cycle_end();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic drain();
    set_id(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      rand_stage();
      settle();
      cycle_end();
    end
  endtask

  initial begin
    // Reset state: decode asks for x1/x2 with garbage on the buses.
    rand_stage();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd1, 1'b1, 1'b0);
    #2;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_fwd1_en", 32'(fwd1_en), 32'd0);
    check("rst_fwd2_en", 32'(fwd2_en), 32'd0);
    check("rst_fwd1_data", fwd1_data, 32'd0);
    check("rst_fwd2_data", fwd2_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_advance();
    inflight.delete();

    // ALU chain: add x1,x1,x2 ; add x1,x1,x3 ; add x1,x1,x4
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd1, 1'b1, 1'b0);
    rand_stage();
    settle();
    check("chain1_fwd1_en", 32'(fwd1_en), 32'd0);
    cycle_end();
    set_id(1'b1, 5'd1, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0);
    set_stage(32'd3, 32'hDEAD_0001, 32'hDEAD_0002);
    settle();
    check("chain2_fwd1_en", 32'(fwd1_en), 32'd1);
    check("chain2_fwd1_data", fwd1_data, 32'd3);
    check("chain2_stall", 32'(stall), 32'd0);
    cycle_end();
    set_id(1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 5'd1, 1'b1, 1'b0);
    set_stage(32'd6, 32'd3, 32'hDEAD_0003);
    settle();
    check("chain3_fwd1_data", fwd1_data, 32'd6);
    check("chain3_stall", 32'(stall), 32'd0);
    cycle_end();
    drain();

    // Load-use: lw x5,0(x0) ; add x6,x5,x5 -> one stall, then forward 7 from MEM.
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    rand_stage();
    settle();
    cycle_end();
    set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    rand_stage();
    settle();
    check("lu_stall", 32'(stall), 32'd1);
    check("lu_fwd1_en_stalled", 32'(fwd1_en), 32'd0);
    cycle_end();
    set_stage(32'hDEAD_0004, 32'd7, 32'hDEAD_0005);
    settle();
    check("lu_stall_released", 32'(stall), 32'd0);
    check("lu_fwd1_data", fwd1_data, 32'd7);
    check("lu_fwd2_data", fwd2_data, 32'd7);
    check("lu_fwd2_en", 32'(fwd2_en), 32'd1);
    cycle_end();
    drain();

    // x0 destination never matches.
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);
    rand_stage();
    settle();
    cycle_end();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0);
    set_stage(32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    settle();
    check("x0_fwd1_en", 32'(fwd1_en), 32'd0);
    check("x0_fwd2_en", 32'(fwd2_en), 32'd0);
    check("x0_fwd1_data", fwd1_data, 32'd0);
    check("x0_stall", 32'(stall), 32'd0);
    cycle_end();
    drain();

    // Youngest producer wins: x1=4 (MEM) older than x1=6 (EX).
    set_id(1'b1, 5'd2, 1'b1, 5'd2, 1'b1, 5'd1, 1'b1, 1'b0);
    settle();
    cycle_end();
    set_id(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0);
    settle();
    cycle_end();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, 1'b0);
    set_stage(32'd6, 32'd4, 32'hDEAD_0006);
    settle();
    check("young_fwd1_data", fwd1_data, 32'd6);
    check("young_fwd1_en", 32'(fwd1_en), 32'd1);
    cycle_end();
    drain();

    // Flush over a pending load-use stall.
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    settle();
    cycle_end();
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);
    settle();
    check("flush_pre_stall", 32'(stall), 32'd1);
    flush = 1'b1;
    cycle_end();
    flush = 1'b0;
    rand_stage();
    settle();
    check("flush_stall", 32'(stall), 32'd0);
    check("flush_fwd1_en", 32'(fwd1_en), 32'd0);
    cycle_end();
    // Flush also drops the instruction entering on that edge.
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    flush = 1'b1;
    settle();
    cycle_end();
    flush = 1'b0;
    set_id(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
    settle();
    check("flush_insert_fwd1_en", 32'(fwd1_en), 32'd0);
    cycle_end();
    drain();

    // Asynchronous reset in the middle of a stalled cycle.
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    settle();
    cycle_end();
    set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    settle();
    check("arst_pre_stall", 32'(stall), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_stall", 32'(stall), 32'd0);
    check("arst_fwd1_en", 32'(fwd1_en), 32'd0);
    check("arst_fwd2_en", 32'(fwd2_en), 32'd0);
`ifdef RAW_HAZ_PERF_EN
    check("arst_perf_stall", perf_stall_cnt, 32'd0);
    check("arst_perf_fwd", perf_fwd_cnt, 32'd0);
`endif
    cycle_end();
    rst = 1'b1;
    settle();
    cycle_end();

    // Randomized traffic on a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      set_id(1'($urandom_range(0, 9) < 8),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 9) < 3));
      flush = ($urandom_range(0, 15) == 0);
      rand_stage();
      settle();
      cycle_end();
    end
    flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/raw_hazard_unit.md
Name: raw_hazard_unit

Overview:
- Parametrised RAW hazard tracker and forwarding unit for the pipelined RV32I core; replaces ad-hoc per-stage comparators in the datapath.
- Keeps a shift-register scoreboard of in-flight destination registers behind decode.
- Compares each decode-stage source against that scoreboard. Drives operand forwarding muxes, or a stall when the producing result is not yet available (e.g. load-use).

Parameters:
XLEN, 32, datapath width
RADDR_W, 5, register address width
DEPTH, 3, tracked stages after decode (index 0 = EX, DEPTH-1 = WB)
ALU_READY, 0, first stage index whose result bus holds a valid ALU result
LOAD_READY, 1, first stage index whose result bus holds valid load data (must be >= ALU_READY and < DEPTH)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
flush  in  1  squash all tracked entries (taken branch/jump)
id_valid  in  1  decode stage holds a real instruction
id_rs1  in  RADDR_W  source 1 address
id_rs2  in  RADDR_W  source 2 address
id_rs1_used  in  1  instruction reads rs1
id_rs2_used  in  1  instruction reads rs2
id_rd  in  RADDR_W  destination address
id_rd_we  in  1  instruction writes rd
id_is_load  in  1  instruction is a load
stage_data  in  DEPTH*XLEN  result bus of each tracked stage, stage i at [i*XLEN +: XLEN]
stall  out  1  hold PC and IF/ID, inject bubble into EX
fwd1_en  out  1  use fwd1_data instead of regfile rs1
fwd1_data  out  XLEN  forwarded rs1 value
fwd2_en  out  1  use fwd2_data instead of regfile rs2
fwd2_data  out  XLEN  forwarded rs2 value

Behaviour:
- Scoreboard entry fields: {vld, rd, we, ld}.
- Reset: all entries cleared. stall, fwd1_en and fwd2_en read 0; fwd*_data read 0.
- Each rising edge: entries shift i -> i+1 and entry DEPTH-1 retires.
  - Entry 0 loads {id_valid & ~stall, id_rd, id_rd_we, id_is_load}.
  - When stall is 1, entry 0 becomes a bubble (vld = 0).
- flush=1: all entries cleared on that edge, including the entry that would have been inserted. flush has priority over stall.
- Match(src, i) = used & vld_i & we_i & (rd_i == src) & (src != 0). x0 never matches.
- Per source: the youngest matching entry (lowest i) wins; older matches are ignored.
- Ready(i) = i >= (ld_i ? LOAD_READY : ALU_READY).
- If the winning entry is ready: fwdN_en = 1 and fwdN_data = stage_data[i].
- If the winning entry is not ready: stall contribution = 1 and fwdN_en = 0.
- No match: fwdN_en = 0 and fwdN_data = 0.
- stall = id_valid & (rs1 not-ready hazard | rs2 not-ready hazard).
- All outputs are combinational from scoreboard state plus id_* inputs: zero-cycle decision latency. Only the scoreboard is registered.
- A stalled instruction re-evaluates each cycle. With defaults, load-use costs exactly one stall cycle.
- The WB-stage entry (DEPTH-1) still forwards, which covers same-cycle regfile write/read.
- Reset asserted mid-stall: stall drops asynchronously; no partial entries survive.
- Parameter check: if LOAD_READY >= DEPTH or ALU_READY > LOAD_READY, raise an error at elaboration.

Optional Feature:
- Macro RAW_HAZ_PERF_EN.
- Defined: adds outputs perf_stall_cnt (32) and perf_fwd_cnt (32).
  - perf_stall_cnt increments on every cycle with stall=1.
  - perf_fwd_cnt increments by (fwd1_en + fwd2_en) on every cycle with id_valid & ~stall.
  - Both counters saturate at 32'hFFFFFFFF, reset to 0, and are unaffected by flush.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (core_pkg): XLEN, RADDR_W, stage index constants (EX=0, MEM=1, WB=2), and the scoreboard entry struct {vld, rd, we, ld}.
- One sub-module: raw_fwd_select, instantiated twice (rs1, rs2). It takes src, used and the scoreboard, and returns {hazard, fwd_en, fwd_data} via youngest-priority search.

Test Plan:
- Back-to-back ALU chain: x1=1, x2=2, x3=3, x4=4; add x1,x1,x2; add x1,x1,x3; add x1,x1,x4.
  - Expect fwd1_en=1 from stage 0 on instructions 2 and 3, stall never asserted.
  - x1 ends at 10 with PC reaching 36 with no extra cycles.
- Load-use: lw x5,0(x0) (mem[0]=7), then add x6,x5,x5.
  - Expect stall=1 for exactly 1 cycle, then fwd1_en=fwd2_en=1 with data 7; x6=14.
- x0 destination: add x0,x1,x2, then add x7,x0,x0.
  - Expect fwd*_en=0 and stall=0; x7=0.
- Youngest priority: add x1,x2,x2 (=4); add x1,x3,x3 (=6); add x8,x1,x0.
  - Expect fwd1_data=6 from stage 0, not 4.
- Flush: lw x5 in EX, assert flush with dependent add x9,x5,x0 in decode.
  - Scoreboard empty on the next cycle, stall=0, no forwarding.
- Async reset during stall: drive rst=0 mid-cycle.
  - Expect stall, fwd1_en and fwd2_en all 0 immediately. With RAW_HAZ_PERF_EN defined, both counters read 0.
